// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard character queue.
// Holds scancode prefixes, the parser state encoding and the keyboardChar bit layout.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXT       = 2'd1,
        ST_BREAK     = 2'd2,
        ST_EXT_BREAK = 2'd3
    } kbd_state_e;

    localparam int KC_NONEMPTY      = 15;
    localparam int KC_OVF           = 14;
    localparam int KC_EXT           = 8;
    localparam int KEY_WORD_DEFAULT = 62;

endpackage

// File: rtl/kbd_char_queue_sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers.
// Flush beats push; push into a full FIFO is accepted only alongside a real pop.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (count == '0);
        full     = (count == (AW+1)'(DEPTH));
        pop_ok   = pop & ~empty & ~flush;
        push_ok  = push & ~flush & (~full | pop_ok);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
        head = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Storage needs no reset: head is masked by empty in the consumer.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: rtl/kbd_char_queue.sv
// PS/2 scancode filter and key-press queue behind dmem's memory-mapped keyboard word.
// Valid/ready: scan_valid is a one-cycle strobe with no backpressure; a hit CPU read pops the head.
module kbd_char_queue
    import kbd_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int inputAbits = 32,
    parameter int Abits      = 12,
    parameter int KEY_WORD   = KEY_WORD_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  scan_valid,
    input  logic [7:0]            scan_code,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [inputAbits-1:0] addr,
    input  logic [31:0]           din,
    output logic [15:0]           keyboardChar,
    output logic                  irq_key,
    output logic [1:0]            state_dbg
);
    kbd_state_e state_q, state_d;
    logic       ovf_q, ovf_d;
    logic       hit, pop_req, flush_req;
    logic       push_req;
    logic [8:0] push_data;
    logic       full, empty;
    logic [8:0] head;
    logic       unused_bits;

    assign unused_bits = ^{addr[inputAbits-1:Abits+2], addr[1:0], din[31:1]};

    always_comb begin
        hit       = (addr[Abits+1:2] == Abits'(KEY_WORD));
        pop_req   = mem_rd & hit;
        flush_req = mem_wr & hit & din[0];
    end

    // Break sequences are swallowed whole; 0xF0 inside a break is the discarded code.
    always_comb begin
        state_d   = state_q;
        push_req  = 1'b0;
        push_data = {1'b0, scan_code};
        if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)        state_d = ST_EXT;
                    else if (scan_code == SC_BREAK) state_d = ST_BREAK;
                    else                            push_req = 1'b1;
                end
                ST_EXT: begin
                    if (scan_code == SC_BREAK) begin
                        state_d = ST_EXT_BREAK;
                    end else if (scan_code != SC_EXT) begin
                        push_req  = 1'b1;
                        push_data = {1'b1, scan_code};
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (flush_req) state_d = ST_IDLE;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (flush_req)                           ovf_d = 1'b0;
        else if (push_req & full & ~pop_req)     ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop_req),
        .flush (flush_req),
        .din   (push_data),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        keyboardChar              = 16'h0000;
        keyboardChar[KC_NONEMPTY] = ~empty;
        keyboardChar[KC_OVF]      = ovf_q;
        if (!empty) begin
            keyboardChar[KC_EXT] = head[8];
            keyboardChar[7:0]    = head[7:0];
        end
        irq_key   = ~empty;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_kbd_char_queue.sv
// Scoreboard bench for kbd_char_queue: queue-based reference model, directed cases, random traffic.
module tb_kbd_char_queue;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [15:0] keyboardChar;
    logic        irq_key;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic [8:0]  model_q[$];
    bit          model_ovf;
    bit          pre_ext;
    bit          pre_brk;

    kbd_char_queue #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .addr         (addr),
        .din          (din),
        .keyboardChar (keyboardChar),
        .irq_key      (irq_key),
        .state_dbg    (state_dbg)
    );

    // Clock/reset block.
    always #5 clock = ~clock;

    function automatic bit is_hit(input logic [31:0] a);
        return a[13:2] == 12'd62;
    endfunction

    function automatic logic [15:0] model_word();
        if (model_q.size() == 0) return {1'b0, model_ovf, 14'd0};
        return {1'b1, model_ovf, 5'd0, model_q[0]};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        model_ovf = 0;
        pre_ext   = 0;
        pre_brk   = 0;
    endtask

    // Reference: prefixes tracked as flags, queue bounded at DEPTH, flush beats everything.
    task automatic model_cycle(input bit sv, input logic [7:0] code, input bit rd,
                               input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit         flush;
        bit         do_push;
        logic [8:0] ent;
        logic [8:0] dropped;
        flush   = wr && is_hit(a) && d[0];
        do_push = 0;
        ent     = '0;
        if (sv) begin
            if (pre_brk) begin
                pre_brk = 0;
                pre_ext = 0;
            end else if (code == 8'hE0) begin
                pre_ext = 1;
            end else if (code == 8'hF0) begin
                pre_brk = 1;
            end else begin
                do_push = 1;
                ent     = {pre_ext, code};
                pre_ext = 0;
            end
        end
        if (flush) begin
            model_clear();
        end else begin
            if (rd && is_hit(a) && model_q.size() > 0) dropped = model_q.pop_front();
            if (do_push) begin
                if (model_q.size() < DEPTH) model_q.push_back(ent);
                else                        model_ovf = 1;
            end
        end
    endtask

    // Driver tasks.
    task automatic step(input bit sv, input logic [7:0] code, input bit rd,
                        input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (rd && is_hit(a)) exp_q.push_back(model_word());
        scan_valid = sv;
        scan_code  = code;
        mem_rd     = rd;
        mem_wr     = wr;
        addr       = a;
        din        = d;
        model_cycle(sv, code, rd, wr, a, d);
        @(posedge clock);
        #1;
        scan_valid = 0;
        mem_rd     = 0;
        mem_wr     = 0;
        addr       = 32'h0;
        din        = 32'h0;
    endtask

    task automatic scan(input logic [7:0] code);
        step(1, code, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic cpu_read(input logic [31:0] a);
        step(0, 8'h00, 1, 0, a, 32'h0);
    endtask

    task automatic cpu_write(input logic [31:0] d);
        step(0, 8'h00, 0, 1, 32'hF8, d);
    endtask

    task automatic do_reset();
        reset      = 1;
        scan_valid = 0;
        mem_rd     = 0;
        mem_wr     = 0;
        scan_code  = 8'h00;
        addr       = 32'h0;
        din        = 32'h0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
    endtask

    // Monitor: every hit read presents the head word; compare it to the oldest expectation.
    always @(negedge clock) begin
        if (!reset && mem_rd && is_hit(addr)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got 0x%h expected no read at %0t", keyboardChar, $time);
            end else begin
                check16("read_head", keyboardChar, exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        check16("reset_word", keyboardChar, 16'h0000);
        check1("reset_irq", irq_key, 1'b0);

        scan(8'h1C);
        check16("push_1c", keyboardChar, 16'h801C);
        check1("irq_after_push", irq_key, 1'b1);
        cpu_read(32'hF8);
        check16("after_pop", keyboardChar, 16'h0000);
        check1("irq_after_pop", irq_key, 1'b0);

        scan(8'hF0); scan(8'h1C);
        check16("break_filtered", keyboardChar, 16'h0000);
        scan(8'hE0); scan(8'h75);
        check16("ext_press", keyboardChar, 16'h8175);
        cpu_read(32'hF8);
        scan(8'hE0); scan(8'hF0); scan(8'h75);
        check16("ext_break_filtered", keyboardChar, 16'h0000);

        for (int i = 0; i < 9; i++) scan(8'h10 + 8'(i));
        check16("overflow_set", keyboardChar, 16'hC010);
        for (int i = 0; i < 8; i++) cpu_read(32'hF8);
        check16("drained_ovf", keyboardChar, 16'h4000);
        cpu_write(32'h1);
        check16("flush_clears_ovf", keyboardChar, 16'h0000);

        for (int i = 0; i < 8; i++) scan(8'h40 + 8'(i));
        check16("full_head", keyboardChar, 16'h8040);
        step(1, 8'h20, 1, 0, 32'hF8, 32'h0);
        check16("full_push_pop", keyboardChar, 16'h8041);
        for (int i = 0; i < 7; i++) cpu_read(32'hF8);
        check16("pushed_last", keyboardChar, 16'h8020);
        cpu_read(32'hF8);
        check16("full_drained", keyboardChar, 16'h0000);

        scan(8'h21); scan(8'h22); scan(8'h23);
        step(1, 8'h33, 0, 1, 32'hF8, 32'h1);
        check16("flush_drops_push", keyboardChar, 16'h0000);
        scan(8'h44);
        cpu_write(32'h0);
        check16("store_din0", keyboardChar, 16'h8044);
        cpu_read(32'hF4);
        check16("nonhit_read", keyboardChar, 16'h8044);
        cpu_read(32'hF8);
        step(0, 8'h00, 1, 0, 32'hF8, 32'h0);
        check16("pop_empty", keyboardChar, 16'h0000);

        scan(8'h55);
        step(0, 8'h00, 1, 1, 32'hF8, 32'h1);
        check16("rd_wr_flush_wins", keyboardChar, 16'h0000);

        scan(8'hF0);
        do_reset();
        scan(8'h1C);
        check16("reset_mid_seq", keyboardChar, 16'h801C);
        cpu_read(32'hF8);

        for (int n = 0; n < 800; n++) begin
            int          r;
            logic [7:0]  code;
            bit          sv, rd, wr;
            logic [31:0] a;
            r    = $urandom_range(0, 9);
            code = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            sv   = ($urandom_range(0, 2) != 0);
            rd   = ($urandom_range(0, 3) == 0);
            wr   = !rd && ($urandom_range(0, 30) == 0);
            a    = ($urandom_range(0, 4) == 0) ? 32'hF4 : 32'hF8;
            step(sv, code, rd, wr, a, 32'($urandom_range(0, 1)));
            check16("rand_word", keyboardChar, model_word());
            check1("rand_irq", irq_key, model_q.size() != 0);
        end

        check1("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kbd_char_queue.md
Name: kbd_char_queue

Overview:
- Sits between the PS/2 scancode receiver and dmem's memory-mapped keyboard word (word index 62, byte address 0xF8); drives dmem's keyboardChar input.
- Filters make/break/extended scancode sequences into key-press events.
- Buffers press events in a small FIFO so the game loop never misses a key.
- Pops the head entry when the CPU reads the keyboard word; flushes on a CPU write to the same word.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- inputAbits, 32, CPU address width.
- Abits, 12, word-address bits decoded, matching dmem.
- KEY_WORD, 62, word index of the keyboard register.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scan_valid  in  1  one-cycle strobe: scan_code is new.
- scan_code  in  8  raw PS/2 scancode byte.
- mem_rd  in  1  CPU load in progress this cycle.
- mem_wr  in  1  CPU store this cycle; same signal as dmem wr.
- addr  in  inputAbits  CPU data address; same bus as dmem addr.
- din  in  32  CPU store data.
- keyboardChar  out  16  to dmem: {nonempty, overflow, 5'b0, extended, code[7:0]}.
- irq_key  out  1  level high while the FIFO is non-empty.

Behaviour:
- Register hit: hit = (addr[Abits+1:2] == KEY_WORD). pop_req = mem_rd & hit. flush_req = mem_wr & hit & din[0].
- Scancode FSM, advances only on scan_valid:
  - IDLE: 0xE0 -> EXT. 0xF0 -> BREAK. Any other code -> push {ext=0, code}, stay IDLE.
  - EXT: 0xF0 -> EXT_BREAK. 0xE0 -> stay EXT. Any other code -> push {ext=1, code}, go IDLE.
  - BREAK: any code -> discard, go IDLE.
  - EXT_BREAK: any code -> discard, go IDLE.
  - 0xF0 seen while in BREAK or EXT_BREAK counts as the discarded code.
- FIFO: 9-bit entries {ext, code}. rd_ptr and wr_ptr are each log2(DEPTH)+1 bits, wrap naturally. count = wr_ptr - rd_ptr.
- Push happens the same cycle scan_valid arrives. The entry is visible on keyboardChar the next cycle; latency is 1 clock.
- Pop takes effect at the clock edge ending the read cycle. The CPU samples the old head combinationally through dmem in that cycle.
- keyboardChar is combinational from registered state only. When empty: nonempty=0, ext and code = 0 (word reads 0x0000 except the overflow bit).
- Push while full without a simultaneous pop: the new entry is dropped and the sticky overflow bit is set.
- Push and pop in the same cycle while full: both occur, count stays DEPTH, overflow unchanged.
- Push and pop in the same cycle while empty: the pop is ignored, the push occurs, count becomes 1.
- Pop while empty: no effect.
- flush_req: sets rd_ptr = wr_ptr, clears overflow, returns the FSM to IDLE. It takes priority over a same-cycle push, which is dropped.
- A store to KEY_WORD with din[0]=0 has no effect. dmem still writes its shadow RAM; that is harmless because dmem muxes keyboardChar on reads.
- mem_rd and mem_wr together is illegal. If it occurs, flush wins.
- Reset: pointers 0, overflow 0, FSM IDLE, keyboardChar = 0x0000, irq_key = 0. Reset mid-sequence, e.g. between 0xF0 and its code, abandons the sequence.

Decomposition:
- Shared package kbd_pkg: scancode constants SC_EXT=8'hE0, SC_BREAK=8'hF0; FSM state encoding (2 bits); keyboardChar bit positions KC_NONEMPTY=15, KC_OVF=14, KC_EXT=8; KEY_WORD default.
- One sub-module, sync_fifo (parameters WIDTH and DEPTH), with push/pop/flush/full/empty/head.
- FSM, address decode and overflow flag live in the top module.

Test Plan:
- Reset, then scan_valid with 0x1C -> next cycle keyboardChar=0x801C and irq_key=1. mem_rd with addr=0xF8 for one cycle -> keyboardChar=0x0000 and irq_key=0 the following cycle.
- Sequence 0xF0, 0x1C -> no push, keyboardChar remains 0x0000. Sequence 0xE0, 0x75 -> keyboardChar=0x8175. Sequence 0xE0, 0xF0, 0x75 -> nothing pushed.
- Push 9 codes 0x10..0x18 with DEPTH=8 -> overflow set. Eight pops return 0xC010..0xC017 in order (overflow bit stays set), then the word reads 0x4000.
- FIFO full, then push 0x20 and pop in the same cycle -> count stays 8, overflow stays 0, 0x20 is read last.
- Three codes queued, then mem_wr to 0xF8 with din=1 -> next cycle keyboardChar=0x0000. Same-cycle scan_valid 0x33 is dropped. A store with din=0 changes nothing.
- mem_rd at address 0xF4 (non-hit) with entries queued -> no pop. Reset asserted after 0xF0 -> a following code 0x1C is pushed normally.
